// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared state encoding and filter length for pwm_capture
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int GLITCH_LEN = 3;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - pin synchroniser, optional glitch filter (PWM_CAPTURE_GLITCH_FILTER_EN), edge detect
module sync_edge_det
  import pwm_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  // Level follows the synchroniser only once GLITCH_LEN consecutive samples agree.
  logic [GLITCH_LEN-2:0] hist_q;
  logic                  filt_q;
  logic                  stable;

  assign stable = (&{sync_out, hist_q}) | ~(|{sync_out, hist_q});
  assign level  = stable ? sync_out : filt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[GLITCH_LEN-3:0], sync_out};
      filt_q <= level;
    end
  end
`else
  assign level = sync_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= level;
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture; PWM_CAPTURE_GLITCH_FILTER_EN enables the input filter
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             rst_i,
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             pwm_i,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] high_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic             level_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic             rise, fall;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] high_cap_q, high_cap_d;
  logic             load, ovf_d, sat;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk_i),
    .rst_n (rst_i),
    .din   (pwm_i),
    .level (level_o),
    .rise  (rise),
    .fall  (fall)
  );

  assign sat     = (cnt_q == CNT_MAX);
  assign cnt_inc = sat ? cnt_q : cnt_q + WIDTH'(1);

  // An edge coinciding with saturation takes priority over the overflow.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_cap_d = high_cap_q;
    load       = 1'b0;
    ovf_d      = 1'b0;
    if (!en_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            cnt_d   = WIDTH'(1);
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            high_cap_d = cnt_q;
            cnt_d      = cnt_inc;
            state_d    = ST_LOW;
          end else if (sat) begin
            ovf_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_LOW: begin
          if (rise) begin
            load    = 1'b1;
            cnt_d   = WIDTH'(1);
            state_d = ST_HIGH;
          end else if (sat) begin
            ovf_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      high_cap_q <= '0;
      period_o   <= '0;
      high_o     <= '0;
      valid_o    <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_cap_q <= high_cap_d;
      valid_o    <= load;
      ovf_o      <= ovf_d;
      if (load) begin
        period_o <= cnt_q;
        high_o   <= high_cap_q;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed table-driven bench for pwm_capture (16-bit and 8-bit instances)
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b1;
  logic        pwm = 1'b0;
  logic [15:0] period16, high16;
  logic [7:0]  period8, high8;
  logic        valid16, ovf16, level16;
  logic        valid8, ovf8, level8;

  int checks = 0;
  int errors = 0;
  int vc16 = 0, vc8 = 0, oc16 = 0, oc8 = 0;
  int lp16 = 0, lh16 = 0, lp8 = 0, lh8 = 0;

  always #5 clk = ~clk;

  pwm_capture #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
    .rst_i(rst), .clk_i(clk), .en_i(en), .pwm_i(pwm),
    .period_o(period16), .high_o(high16), .valid_o(valid16), .ovf_o(ovf16), .level_o(level16)
  );

  pwm_capture #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .rst_i(rst), .clk_i(clk), .en_i(en), .pwm_i(pwm),
    .period_o(period8), .high_o(high8), .valid_o(valid8), .ovf_o(ovf8), .level_o(level8)
  );

  always @(negedge clk) begin
    if (valid16) begin vc16++; lp16 = int'(period16); lh16 = int'(high16); end
    if (valid8)  begin vc8++;  lp8  = int'(period8);  lh8  = int'(high8);  end
    if (ovf16) oc16++;
    if (ovf8)  oc8++;
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int GL_CNT = 2, GL_PER = 100, GL_HI = 25;
`else
  localparam int GL_CNT = 3, GL_PER = 45,  GL_HI = 2;
`endif

  typedef struct {
    int hi;
    int per;
    int exp_hi;
    int exp_per;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_period(input int hi, input int per);
    pwm = 1'b1;
    repeat (hi) tick();
    pwm = 1'b0;
    repeat (per - hi) tick();
  endtask

  initial begin
    int b16, b8, bo16, bo8;
    tbl[0] = '{25, 100, 25, 100};
    tbl[1] = '{25, 100, 25, 100};
    tbl[2] = '{25, 100, 25, 100};
    tbl[3] = '{25, 100, 25, 100};
    tbl[4] = '{25, 100, 25, 100};
    tbl[5] = '{60, 100, 60, 100};
    tbl[6] = '{60, 100, 60, 100};
    tbl[7] = '{10, 40, 10, 40};
    tbl[8] = '{3, 6, 3, 6};
    tbl[9] = '{200, 250, 200, 250};

    repeat (3) tick();
    chk("rst_period16", int'(period16), 0);
    chk("rst_high16", int'(high16), 0);
    chk("rst_valid16", int'(valid16), 0);
    chk("rst_ovf16", int'(ovf16), 0);
    chk("rst_level16", int'(level16), 0);
    chk("rst_period8", int'(period8), 0);
    rst = 1'b1;
    repeat (5) tick();

    // Continuous stream: vector i's valid lands early in vector i+1.
    b16 = vc16; b8 = vc8;
    for (int i = 0; i < 10; i++) begin
      drive_period(tbl[i].hi, tbl[i].per);
      chk($sformatf("stream_cnt16[%0d]", i), vc16 - b16, i);
      chk($sformatf("stream_cnt8[%0d]", i), vc8 - b8, i);
      if (i > 0) begin
        chk($sformatf("period16[%0d]", i - 1), lp16, tbl[i-1].exp_per);
        chk($sformatf("high16[%0d]", i - 1), lh16, tbl[i-1].exp_hi);
        chk($sformatf("period8[%0d]", i - 1), lp8, tbl[i-1].exp_per);
        chk($sformatf("high8[%0d]", i - 1), lh8, tbl[i-1].exp_hi);
      end
    end
    pwm = 1'b1;
    repeat (10) tick();
    chk("close_cnt16", vc16 - b16, 10);
    chk("close_period16", lp16, 250);
    chk("close_high16", lh16, 200);

    // Stuck high: the 8-bit counter saturates.
    b8 = vc8; bo8 = oc8; bo16 = oc16;
    repeat (300) tick();
    chk("ovf_hi_cnt8", oc8 - bo8, 1);
    chk("ovf_hi_cnt16", oc16 - bo16, 0);
    chk("ovf_hi_level8", int'(level8), 1);
    chk("ovf_hi_period8", int'(period8), 250);
    chk("ovf_hi_high8", int'(high8), 200);
    chk("ovf_hi_valid8", vc8 - b8, 0);

    // Stuck low after a short pulse.
    pwm = 1'b0;
    repeat (10) tick();
    pwm = 1'b1;
    repeat (20) tick();
    pwm = 1'b0;
    repeat (300) tick();
    chk("ovf_lo_cnt8", oc8 - bo8, 2);
    chk("ovf_lo_level8", int'(level8), 0);
    chk("ovf_lo_valid8", vc8 - b8, 0);
    chk("ovf_lo_period8", int'(period8), 250);

    // Enable dropped mid-HIGH.
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    tick();
    b16 = vc16; b8 = vc8;
    pwm = 1'b1;
    repeat (10) tick();
    en = 1'b0;
    repeat (10) tick();
    en = 1'b1;
    repeat (5) tick();
    pwm = 1'b0;
    repeat (75) tick();
    drive_period(25, 100);
    chk("en_no_valid16", vc16 - b16, 0);
    chk("en_no_valid8", vc8 - b8, 0);
    drive_period(40, 100);
    chk("en_valid16", vc16 - b16, 1);
    chk("en_period16", lp16, 100);
    chk("en_high16", lh16, 25);

    // Asynchronous reset mid-LOW.
    pwm = 1'b1;
    repeat (25) tick();
    pwm = 1'b0;
    repeat (30) tick();
    chk("pre_rst_high16", int'(high16), 40);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_period16", int'(period16), 0);
    chk("arst_high16", int'(high16), 0);
    chk("arst_valid16", int'(valid16), 0);
    chk("arst_ovf16", int'(ovf16), 0);
    chk("arst_period8", int'(period8), 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    b16 = vc16;
    drive_period(25, 100);
    chk("arst_arm_only16", vc16 - b16, 0);
    drive_period(25, 100);
    chk("arst_valid16", vc16 - b16, 1);
    chk("arst_meas_period16", lp16, 100);
    chk("arst_meas_high16", lh16, 25);

    // Two-cycle glitch inside the low phase.
    b16 = vc16;
    pwm = 1'b1; repeat (25) tick();
    pwm = 1'b0; repeat (30) tick();
    pwm = 1'b1; repeat (2) tick();
    pwm = 1'b0; repeat (43) tick();
    drive_period(25, 100);
    chk("glitch_cnt16", vc16 - b16, GL_CNT);
    chk("glitch_period16", lp16, GL_PER);
    chk("glitch_high16", lh16, GL_HI);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Input-capture counterpart of the team's PWM generator: measures an incoming PWM waveform's period and high time, in clk_i cycles.
- Synchronises the asynchronous pwm_i pin, detects edges and runs a small FSM. Publishes a {period, high} pair with a one-cycle valid strobe on each completed cycle.
- Sits in the io-other peripheral group, typically behind a register interface or feeding a servo/fan-tach decoder.

Parameters:
- WIDTH, 16, width of the cycle counter and of period_o/high_o; maximum measurable interval is 2^WIDTH-1 cycles.
- SYNC_STAGES, 2, number of synchroniser flops on pwm_i; legal range 2..4.

Ports:
- rst_i  input  1  asynchronous reset, active-low.
- clk_i  input  1  single system clock; all logic is on the rising edge.
- en_i  input  1  capture enable; low synchronously returns the block to IDLE.
- pwm_i  input  1  asynchronous PWM input pin.
- period_o  output  WIDTH  last measured period: cycles from rise to the next rise.
- high_o  output  WIDTH  last measured high time: cycles from rise to fall.
- valid_o  output  1  one-cycle strobe when period_o/high_o update.
- ovf_o  output  1  one-cycle strobe when the counter saturates without an expected edge.
- level_o  output  1  synchronised pwm_i level, for 0%/100% duty reporting after ovf_o.

Behaviour:
- Reset (rst_i=0, async):
  - period_o=0, high_o=0, valid_o=0, ovf_o=0, level_o=0.
  - Synchroniser flops=0, cnt=0, high_cap=0, state=IDLE.
- Synchroniser: SYNC_STAGES flops, then one history flop `prev`.
  - rise = sync & ~prev; fall = ~sync & prev; level_o = sync.
- Detection latency: a pin edge is detected SYNC_STAGES+1 clk_i edges after the first edge that samples the new level.
- en_i=0: state<=IDLE, cnt<=0, valid_o=0, ovf_o=0. period_o/high_o hold their values. The synchroniser keeps running, so no spurious edge appears on re-enable.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: wait for rise, ignoring fall. On rise: cnt<=1, go to HIGH.
  - HIGH: cnt<=cnt+1 each cycle. On fall: high_cap<=cnt, go to LOW.
  - LOW: cnt<=cnt+1 each cycle. On rise: period_o<=cnt, high_o<=high_cap, valid_o<=1 for one cycle, cnt<=1, go to HIGH.
- Back-to-back periods are measured continuously with no dead cycle: the closing rise starts the next measurement.
- Counting rule: with the rise detected in cycle 0, an edge detected in cycle k captures the value k. A fall in cycle h gives high=h; the next rise in cycle p gives period=p.
- Saturation: in HIGH or LOW, if cnt==2^WIDTH-1 and no edge occurs this cycle:
  - ovf_o<=1 for one cycle, state<=IDLE, cnt<=0.
  - period_o/high_o are not updated.
  - The firmware reads level_o to tell 100% duty (stuck in HIGH) from 0% duty (stuck in LOW).
- Simultaneous events:
  - An edge in the same cycle as saturation wins: it is processed normally and ovf_o stays 0.
  - en_i=0 overrides everything.
- Counter width is exactly WIDTH; cnt never wraps.
- Reset mid-measurement: all state is discarded and the first rise after release only arms the block (no valid_o).

Optional Feature:
- Macro PWM_CAPTURE_GLITCH_FILTER_EN.
- Defined: a 3-sample majority/stability filter follows the synchroniser. The filtered level changes only after 3 consecutive equal samples, so pulses shorter than 3 cycles are rejected. Detection latency grows by 2 cycles, and measured intervals are unchanged for clean signals.
- Undefined: the filter is absent and the synchroniser output feeds edge detection directly.

Decomposition:
- Shared package pwm_capture_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_HIGH=2'd1, ST_LOW=2'd2.
  - Filter length constant GLITCH_LEN=3.
- One sub-module, sync_edge_det: parameterised synchroniser plus optional filter plus rise/fall/level outputs. It is reusable by other io blocks.
- The FSM and counters stay in pwm_capture.

Test Plan:
- WIDTH=16, pwm_i period 100 clk with 25 high, 5 periods → valid_o pulses every 100 cycles from the second rise on, period_o=100, high_o=25; the first rise produces no valid.
- Duty change mid-stream from 25/100 to 60/100 → the next valid reports high_o=60, period_o=100; no missed or duplicated strobe.
- WIDTH=8, pwm_i held high after a rise → ovf_o pulses once at cnt=255, level_o=1, period_o/high_o unchanged; repeat held low → ovf_o once, level_o=0.
- en_i dropped for 10 cycles mid-HIGH, then re-enabled → no valid for the interrupted period; the first valid comes one full period after the first rise following re-enable.
- rst_i asserted mid-LOW, asynchronously between clock edges → all outputs 0 immediately; after release the first rise arms only.
- With PWM_CAPTURE_GLITCH_FILTER_EN, a 2-cycle high glitch inside the low phase of a 100/25 signal → ignored, period_o=100, high_o=25. Without the macro, the same stimulus yields a spurious short measurement.
